buzzer_pattern_gen: RTL and testbench

// Parametrised alarm-tone generator for the clock board piezo buzzer. Produces a square wave at
// one of two programmable pitches (A/B), shaped by a selectable pattern (continuous, siren, beep,

---
 rtl/buzzer_pkg.sv | 42 ++++
 rtl/buzzer_tone_div.sv | 41 ++++
 rtl/buzzer_pattern_gen.sv | 156 +++++++++++++++
 tb/tb_buzzer_pattern_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - shared state encodings, mode constants and pattern table for the buzzer
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TONE_A = 2'd1,
        ST_TONE_B = 2'd2,
        ST_SILENT = 2'd3
    } state_t;

    localparam logic [1:0] MODE_CONT  = 2'd0;
    localparam logic [1:0] MODE_SIREN = 2'd1;
    localparam logic [1:0] MODE_BEEP  = 2'd2;
    localparam logic [1:0] MODE_CHIRP = 2'd3;

    // Index of the final segment of each pattern (pattern length minus one).
    function automatic logic [1:0] pat_last_idx(input logic [1:0] mode);
        case (mode)
            MODE_CONT:  pat_last_idx = 2'd0;
            MODE_SIREN: pat_last_idx = 2'd1;
            MODE_BEEP:  pat_last_idx = 2'd1;
            default:    pat_last_idx = 2'd3;
        endcase
    endfunction

    // State played during segment idx of the given pattern.
    function automatic state_t pat_seg(input logic [1:0] mode, input logic [1:0] idx);
        case (mode)
            MODE_CONT:  pat_seg = ST_TONE_A;
            MODE_SIREN: pat_seg = idx[0] ? ST_TONE_B : ST_TONE_A;
            MODE_BEEP:  pat_seg = idx[0] ? ST_SILENT : ST_TONE_A;
            default: begin
                case (idx)
                    2'd0:    pat_seg = ST_TONE_A;
                    2'd1:    pat_seg = ST_TONE_B;
                    default: pat_seg = ST_SILENT;
                endcase
            end
        endcase
    endfunction

endpackage

// File: rtl/buzzer_tone_div.sv
// rtl/buzzer_tone_div.sv - half-period divider producing the square-wave tone
// Ports: i_clk, i_rst_n (sync, active low); i_clr forces output low; i_load restarts the
// divider at i_half-1 with output low; i_en counts down and toggles o_tone at zero.
module buzzer_tone_div #(
    parameter int DIV_W = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_half,
    output logic             o_tone
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tone;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= i_half - DIV_W'(1);
            r_tone <= 1'b0;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_tone <= ~r_tone;
                r_cnt  <= i_half - DIV_W'(1);
            end else begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
        end
    end

    assign o_tone = r_tone;

endmodule

// File: rtl/buzzer_pattern_gen.sv
// rtl/buzzer_pattern_gen.sv - two-pitch alarm tone generator with repeating segment patterns
// Ports: Clk_50MHz, Rst_n (sync, active low); Start/Stop control; Mode, Half_a, Half_b, Reps
// configuration latched on Start; Buzzer_out square wave; Busy while a pattern runs;
// Done one-cycle pulse after Reps patterns complete.
import buzzer_pkg::*;

module buzzer_pattern_gen #(
    parameter int DIV_W   = 17,
    parameter int SEG_CYC = 6250000,
    parameter int SEG_W   = 23,
    parameter int REP_W   = 8
) (
    input  logic             Clk_50MHz,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Stop,
    input  logic [1:0]       Mode,
    input  logic [DIV_W-1:0] Half_a,
    input  logic [DIV_W-1:0] Half_b,
    input  logic [REP_W-1:0] Reps,
    output logic             Buzzer_out,
    output logic             Busy,
    output logic             Done
);

    localparam logic [SEG_W-1:0] SEG_LOAD = SEG_W'(SEG_CYC - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_mode;
    logic [DIV_W-1:0] r_half_a;
    logic [DIV_W-1:0] r_half_b;
    logic [REP_W-1:0] r_reps;
    logic [REP_W-1:0] r_rep_cnt;
    logic [SEG_W-1:0] r_seg_cnt;
    logic [1:0]       r_seg_idx;
    logic             r_done;

    logic             w_done_next;
    logic             w_start;
    logic             w_seg_end;
    logic             w_last_seg;
    logic [REP_W-1:0] w_rep_next;
    logic [DIV_W-1:0] w_half_a_in;
    logic [DIV_W-1:0] w_half_b_in;
    logic [DIV_W-1:0] w_reload;
    logic             w_next_is_tone;
    logic             w_div_clr;
    logic             w_div_load;
    logic             w_div_en;
    logic             w_tone;

    // Half-periods below 2 would stall or glitch the divider.
    assign w_half_a_in = (Half_a < DIV_W'(2)) ? DIV_W'(2) : Half_a;
    assign w_half_b_in = (Half_b < DIV_W'(2)) ? DIV_W'(2) : Half_b;

    assign w_start    = Start && !Stop;
    assign w_seg_end  = (r_seg_cnt == '0);
    assign w_last_seg = (r_seg_idx == pat_last_idx(r_mode));
    assign w_rep_next = r_rep_cnt + REP_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_done_next  = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_start) begin
                w_next_state = pat_seg(Mode, 2'd0);
            end
        end else if (Stop) begin
            w_next_state = ST_IDLE;
        end else if (w_seg_end) begin
            if (w_last_seg) begin
                if ((r_reps != '0) && (w_rep_next == r_reps)) begin
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_next_state = pat_seg(r_mode, 2'd0);
                end
            end else begin
                w_next_state = pat_seg(r_mode, r_seg_idx + 2'd1);
            end
        end
    end

    // Leaving IDLE the config is not latched yet, so the clamped inputs feed the divider;
    // every pattern opens with tone A.
    always_comb begin
        w_reload = r_half_a;
        if (r_state == ST_IDLE) begin
            w_reload = w_half_a_in;
        end else if (w_next_state == ST_TONE_B) begin
            w_reload = r_half_b;
        end
    end

    // Only a change of state restarts the divider; a tone self-loop keeps its phase.
    assign w_next_is_tone = (w_next_state == ST_TONE_A) || (w_next_state == ST_TONE_B);
    assign w_div_clr      = !w_next_is_tone;
    assign w_div_load     = w_next_is_tone && (w_next_state != r_state);
    assign w_div_en       = w_next_is_tone && (w_next_state == r_state);

    always_ff @(posedge Clk_50MHz) begin
        if (!Rst_n) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b0;
            r_mode    <= '0;
            r_half_a  <= '0;
            r_half_b  <= '0;
            r_reps    <= '0;
            r_rep_cnt <= '0;
            r_seg_cnt <= '0;
            r_seg_idx <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_next;
            if (r_state == ST_IDLE) begin
                if (w_start) begin
                    r_mode    <= Mode;
                    r_half_a  <= w_half_a_in;
                    r_half_b  <= w_half_b_in;
                    r_reps    <= Reps;
                    r_rep_cnt <= '0;
                    r_seg_cnt <= SEG_LOAD;
                    r_seg_idx <= 2'd0;
                end
            end else if (w_seg_end) begin
                r_seg_cnt <= SEG_LOAD;
                if (w_last_seg) begin
                    r_seg_idx <= 2'd0;
                    r_rep_cnt <= w_rep_next;
                end else begin
                    r_seg_idx <= r_seg_idx + 2'd1;
                end
            end else begin
                r_seg_cnt <= r_seg_cnt - SEG_W'(1);
            end
        end
    end

    buzzer_tone_div #(
        .DIV_W (DIV_W)
    ) u_tone_div (
        .i_clk   (Clk_50MHz),
        .i_rst_n (Rst_n),
        .i_clr   (w_div_clr),
        .i_load  (w_div_load),
        .i_en    (w_div_en),
        .i_half  (w_reload),
        .o_tone  (w_tone)
    );

    assign Buzzer_out = w_tone;
    assign Busy       = (r_state != ST_IDLE);
    assign Done       = r_done;

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// tb/tb_buzzer_pattern_gen.sv - directed self-checking bench for buzzer_pattern_gen
module tb_buzzer_pattern_gen;

    localparam int SEG = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [16:0] half_a;
    logic [16:0] half_b;
    logic [7:0]  reps;
    logic        buz;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int m_mode;
    int m_ha;
    int m_hb;
    int m_reps;

    always #5 clk = ~clk;

    buzzer_pattern_gen #(
        .DIV_W   (17),
        .SEG_CYC (SEG),
        .SEG_W   (5),
        .REP_W   (8)
    ) dut (
        .Clk_50MHz  (clk),
        .Rst_n      (rst_n),
        .Start      (start),
        .Stop       (stop),
        .Mode       (mode),
        .Half_a     (half_a),
        .Half_b     (half_b),
        .Reps       (reps),
        .Buzzer_out (buz),
        .Busy       (busy),
        .Done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = silent, 1 = tone A, 2 = tone B
    function automatic int seg_kind(input int md, input int idx);
        case (md)
            0:       return 1;
            1:       return (idx % 2 == 1) ? 2 : 1;
            2:       return (idx % 2 == 1) ? 0 : 1;
            default: return (idx == 0) ? 1 : ((idx == 1) ? 2 : 0);
        endcase
    endfunction

    function automatic int plen(input int md);
        if (md == 0) return 1;
        if (md == 3) return 4;
        return 2;
    endfunction

    // Expected outputs c cycles after the Start edge.
    task automatic check_cycle(input int c);
        int p, total, e_busy, e_done, e_out, k, h, tt;
        p      = plen(m_mode);
        total  = m_reps * p * SEG;
        e_busy = 1;
        e_done = 0;
        e_out  = 0;
        if (m_reps != 0 && c >= total) begin
            e_busy = 0;
            e_done = (c == total) ? 1 : 0;
        end else begin
            k = seg_kind(m_mode, (c / SEG) % p);
            if (k != 0) begin
                h = (k == 1) ? m_ha : m_hb;
                if (h < 2) h = 2;
                tt = (m_mode == 0) ? c : (c % SEG);
                e_out = (tt / h) % 2;
            end
        end
        chk($sformatf("m%0d busy@%0d", m_mode, c), {31'd0, busy}, e_busy);
        chk($sformatf("m%0d done@%0d", m_mode, c), {31'd0, done}, e_done);
        chk($sformatf("m%0d buz@%0d", m_mode, c), {31'd0, buz}, e_out);
    endtask

    task automatic start_pat(input int md, input int ha, input int hb, input int rp);
        m_mode = md; m_ha = ha; m_hb = hb; m_reps = rp;
        mode   = 2'(md);
        half_a = 17'(ha);
        half_b = 17'(hb);
        reps   = 8'(rp);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle(cyc);
            tick();
            cyc++;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " buz"},  {31'd0, buz},  32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b1;
        stop   = 1'b0;
        mode   = 2'd0;
        half_a = 17'd4;
        half_b = 17'd4;
        reps   = 8'd0;

        // Reset held with Start asserted
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_quiet($sformatf("reset%0d", i));
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_quiet("post_reset");

        // Continuous tone, run until Stop
        start_pat(0, 4, 4, 0);
        step(200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_quiet("cont_stop");
        tick();
        chk_quiet("cont_stop_idle");

        // Siren, two repetitions
        start_pat(1, 3, 5, 2);
        step(86);

        // Beep with clamped half-period, three repetitions
        start_pat(2, 0, 9, 3);
        step(126);

        // Chirp, single repetition
        start_pat(3, 2, 6, 1);
        step(86);

        // Start and Stop together: Stop wins
        mode   = 2'd1;
        half_a = 17'd3;
        reps   = 8'd1;
        start  = 1'b1;
        stop   = 1'b1;
        tick();
        start  = 1'b0;
        stop   = 1'b0;
        chk_quiet("start_stop");
        tick();
        chk_quiet("start_stop_idle");

        // Start while busy with a new pitch is ignored
        start_pat(0, 3, 3, 0);
        step(10);
        half_a = 17'd7;
        mode   = 2'd2;
        start  = 1'b1;
        check_cycle(cyc);
        tick();
        start  = 1'b0;
        cyc++;
        step(30);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_quiet("restart_stop");

        // Reset in the middle of tone B
        start_pat(1, 3, 5, 0);
        step(25);
        rst_n = 1'b0;
        tick();
        chk_quiet("mid_reset");
        tick();
        chk_quiet("mid_reset_hold");
        rst_n = 1'b1;
        tick();
        chk_quiet("mid_reset_release");

        // Stop coincident with the final segment end suppresses Done
        start_pat(1, 3, 5, 1);
        step(39);
        check_cycle(cyc);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_quiet("stop_at_end");
        tick();
        chk_quiet("stop_at_end_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
